// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALUControl encodings used by the decoder, the control unit and the
// shared ALU datapath, plus a helper that flags codes the ALU cannot execute.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Returns 1 for any ALUControl code without an implemented operation.
  function automatic logic alu_unsupported(input logic [2:0] ctrl);
    logic unsup;
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: unsup = 1'b0;
      default:                                   unsup = 1'b1;
    endcase
    return unsup;
  endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: add, sub, and, or, signed set-less-than.
// Ports:
//   a, b    [WIDTH-1:0]  operands
//   ctrl    [2:0]        ALUControl code (see alu_pkg)
//   result  [WIDTH-1:0]  operation result; 0 for unsupported codes
//   zero                 result == 0
//   err                  ctrl was an unsupported code
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  logic slt_s;

  assign slt_s = ($signed(a) < $signed(b)) ? 1'b1 : 1'b0;

  // Operation select; add/sub wrap naturally at WIDTH bits.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_s};
      default: result = {WIDTH{1'b0}};
    endcase
  end

  assign zero = (result == {WIDTH{1'b0}});
  assign err  = alu_unsupported(ctrl);

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between requester 0 (main datapath) and
// requester 1 (address/branch helper). Round-robin grant, at most one op per
// cycle, each requester's result held in its own registered response slot.
// Ports:
//   clk, rst                      clock (rising) and async active-high reset
//   reqN_valid/_ready             request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_ctrl     operands and ALUControl code
//   rspN_valid/_ready             response slot handshake
//   rspN_result, rspN_zero/_err   registered ALU result and flags
//   ops_done      [CNT_W-1:0]     saturating count of accepted operations
// -----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [CNT_W-1:0] ops_done
);

  logic             free0_s, free1_s;
  logic             elig0_s, elig1_s;
  logic             grant0_s, grant1_s, accept_s;
  logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_res_s;
  logic [2:0]       alu_ctrl_s;
  logic             alu_zero_s, alu_err_s;

  logic             rr_last_r;
  logic             rsp0_valid_r, rsp1_valid_r;
  logic [WIDTH-1:0] rsp0_result_r, rsp1_result_r;
  logic             rsp0_zero_r, rsp1_zero_r;
  logic             rsp0_err_r, rsp1_err_r;
  logic [CNT_W-1:0] ops_done_r;

  // A slot draining this cycle can accept a new result at the same edge.
  assign free0_s = !rsp0_valid_r || rsp0_ready;
  assign free1_s = !rsp1_valid_r || rsp1_ready;
  assign elig0_s = req0_valid && free0_s;
  assign elig1_s = req1_valid && free1_s;

  // Ready only looks at the other side's eligibility, never at its own valid,
  // so a requester may safely wait for ready before raising valid.
  // rr_last = 0 favours requester 1, rr_last = 1 favours requester 0.
  assign req0_ready = free0_s && !(elig1_s && !rr_last_r);
  assign req1_ready = free1_s && !(elig0_s &&  rr_last_r);

  assign grant0_s = req0_valid && req0_ready;
  assign grant1_s = req1_valid && req1_ready;
  assign accept_s = grant0_s || grant1_s;

  // Steer the granted requester's operands into the shared ALU.
  always_comb begin
    alu_a_s    = req0_a;
    alu_b_s    = req0_b;
    alu_ctrl_s = req0_ctrl;
    if (grant1_s) begin
      alu_a_s    = req1_a;
      alu_b_s    = req1_b;
      alu_ctrl_s = req1_ctrl;
    end else begin
      alu_a_s    = req0_a;
      alu_b_s    = req0_b;
      alu_ctrl_s = req0_ctrl;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a_s),
    .b      (alu_b_s),
    .ctrl   (alu_ctrl_s),
    .result (alu_res_s),
    .zero   (alu_zero_s),
    .err    (alu_err_s)
  );

  // Round-robin pointer: moves only on a real accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= 1'b1;
    end else if (grant0_s) begin
      rr_last_r <= 1'b0;
    end else if (grant1_s) begin
      rr_last_r <= 1'b1;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  // Response slot 0: reload on accept, else clear on consume, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_r  <= 1'b0;
      rsp0_result_r <= {WIDTH{1'b0}};
      rsp0_zero_r   <= 1'b0;
      rsp0_err_r    <= 1'b0;
    end else if (grant0_s) begin
      rsp0_valid_r  <= 1'b1;
      rsp0_result_r <= alu_res_s;
      rsp0_zero_r   <= alu_zero_s;
      rsp0_err_r    <= alu_err_s;
    end else if (rsp0_ready) begin
      rsp0_valid_r  <= 1'b0;
    end else begin
      rsp0_valid_r  <= rsp0_valid_r;
    end
  end

  // Response slot 1: reload on accept, else clear on consume, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid_r  <= 1'b0;
      rsp1_result_r <= {WIDTH{1'b0}};
      rsp1_zero_r   <= 1'b0;
      rsp1_err_r    <= 1'b0;
    end else if (grant1_s) begin
      rsp1_valid_r  <= 1'b1;
      rsp1_result_r <= alu_res_s;
      rsp1_zero_r   <= alu_zero_s;
      rsp1_err_r    <= alu_err_s;
    end else if (rsp1_ready) begin
      rsp1_valid_r  <= 1'b0;
    end else begin
      rsp1_valid_r  <= rsp1_valid_r;
    end
  end

  // Saturating accepted-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_r <= {CNT_W{1'b0}};
    end else if (accept_s && (ops_done_r != {CNT_W{1'b1}})) begin
      ops_done_r <= ops_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ops_done_r <= ops_done_r;
    end
  end

  assign rsp0_valid  = rsp0_valid_r;
  assign rsp0_result = rsp0_result_r;
  assign rsp0_zero   = rsp0_zero_r;
  assign rsp0_err    = rsp0_err_r;
  assign rsp1_valid  = rsp1_valid_r;
  assign rsp1_result = rsp1_result_r;
  assign rsp1_zero   = rsp1_zero_r;
  assign rsp1_err    = rsp1_err_r;
  assign ops_done    = ops_done_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with a 4-bit operation counter.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_ctrl;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_ctrl;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_zero, rsp1_err;
  logic [3:0]  ops_done;

  int n_checks;
  int n_errors;

  alu_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_err    (rsp1_err),
    .ops_done    (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_ctrl = 3'b000;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_ctrl = 3'b000;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // reset state
    tick();
    tick();
    check_eq("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check_eq("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("rst_rsp0_result", rsp0_result, 32'd0);
    check_eq("rst_ops_done", 32'(ops_done), 32'd0);
    rst = 1'b0;

    // single add from requester 0
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b000;
    #1;
    check_eq("add_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    check_eq("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check_eq("add_result", rsp0_result, 32'd8);
    check_eq("add_zero", 32'(rsp0_zero), 32'd0);
    check_eq("add_err", 32'(rsp0_err), 32'd0);
    check_eq("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("add_ops_done", 32'(ops_done), 32'd1);
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    tick();
    check_eq("drain_rsp0_valid", 32'(rsp0_valid), 32'd0);

    // contention after reset: req0 first, then strict alternation
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd7;  req0_b = 32'd7; req0_ctrl = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd4; req1_ctrl = 3'b000;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    check_eq("rr0_req0_ready", 32'(req0_ready), 32'd1);
    check_eq("rr0_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check_eq("rr0_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check_eq("sub_result", rsp0_result, 32'd0);
    check_eq("sub_zero", 32'(rsp0_zero), 32'd1);
    check_eq("rr0_rsp1_valid", 32'(rsp1_valid), 32'd0);
    #1;
    check_eq("rr1_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("rr1_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    check_eq("rr1_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check_eq("rr1_rsp1_result", rsp1_result, 32'd14);
    check_eq("rr1_rsp0_valid", 32'(rsp0_valid), 32'd0);
    #1;
    check_eq("rr2_req0_ready", 32'(req0_ready), 32'd1);
    check_eq("rr2_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check_eq("rr2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check_eq("rr2_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("rr2_ops_done", 32'(ops_done), 32'd3);

    // slot 0 back-pressure: req0 blocked, req1 served every cycle
    rsp0_ready = 1'b0;
    req0_a = 32'h123;
    #1;
    check_eq("bp_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("bp_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    check_eq("bp_rsp1_result", rsp1_result, 32'd14);
    check_eq("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check_eq("bp_rsp0_result", rsp0_result, 32'd0);
    req1_a = 32'd3; req1_b = 32'd9; req1_ctrl = 3'b010;
    #1;
    check_eq("bp2_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("bp2_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    check_eq("and_result", rsp1_result, 32'd1);
    check_eq("bp2_rsp0_result", rsp0_result, 32'd0);
    check_eq("bp2_rsp0_zero", 32'(rsp0_zero), 32'd1);
    check_eq("bp2_ops_done", 32'(ops_done), 32'd5);

    // both slots full, nothing drains
    rsp1_ready = 1'b0;
    #1;
    check_eq("full_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("full_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check_eq("full_ops_done", 32'(ops_done), 32'd5);
    check_eq("full_rsp1_result", rsp1_result, 32'd1);
    check_eq("full_rsp1_valid", 32'(rsp1_valid), 32'd1);

    // idle cycle kept priority with req0 (last grant was req1)
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_ctrl = 3'b101;
    #1;
    check_eq("idle_req0_ready", 32'(req0_ready), 32'd1);
    check_eq("idle_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check_eq("slt_result", rsp0_result, 32'd1);
    check_eq("slt_err", 32'(rsp0_err), 32'd0);
    check_eq("slt_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("slt_ops_done", 32'(ops_done), 32'd6);

    // unsupported code, then or
    req1_valid = 1'b0;
    req0_a = 32'd5; req0_b = 32'd6; req0_ctrl = 3'b100;
    #1;
    check_eq("bad_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    check_eq("bad_result", rsp0_result, 32'd0);
    check_eq("bad_err", 32'(rsp0_err), 32'd1);
    check_eq("bad_zero", 32'(rsp0_zero), 32'd1);
    req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F; req0_ctrl = 3'b011;
    tick();
    check_eq("or_result", rsp0_result, 32'h0000_00FF);
    check_eq("or_err", 32'(rsp0_err), 32'd0);
    check_eq("or_ops_done", 32'(ops_done), 32'd8);

    // reset while slot 1 is full and an accept is in progress
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b000;
    rsp1_ready = 1'b0;
    tick();
    check_eq("pre_rst_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check_eq("pre_rst_rsp1_result", rsp1_result, 32'd2);
    check_eq("pre_rst_ops_done", 32'(ops_done), 32'd9);
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_ctrl = 3'b000;
    #1;
    check_eq("pre_rst_req0_ready", 32'(req0_ready), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check_eq("mid_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("mid_rst_rsp1_result", rsp1_result, 32'd0);
    check_eq("mid_rst_ops_done", 32'(ops_done), 32'd0);
    tick();
    check_eq("rst_edge_rsp0_valid", 32'(rsp0_valid), 32'd0);
    rst = 1'b0;
    rsp1_ready = 1'b1;
    #1;
    check_eq("post_rst_req0_ready", 32'(req0_ready), 32'd1);
    check_eq("post_rst_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check_eq("post_rst_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check_eq("post_rst_rsp0_result", rsp0_result, 32'd4);
    check_eq("post_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("post_rst_ops_done", 32'(ops_done), 32'd1);

    // back-to-back ops from req0, counter runs into saturation
    req1_valid = 1'b0;
    req0_ctrl  = 3'b000;
    req0_b     = 32'd100;
    for (int i = 0; i < 14; i++) begin
      req0_a = 32'(i);
      tick();
      check_eq("b2b_valid", 32'(rsp0_valid), 32'd1);
      check_eq("b2b_result", rsp0_result, 32'(i + 100));
      check_eq("b2b_ops_done", 32'(ops_done), 32'(i + 2));
    end
    check_eq("sat_reach", 32'(ops_done), 32'd15);
    tick();
    tick();
    check_eq("sat_hold", 32'(ops_done), 32'd15);
    check_eq("sat_last_result", rsp0_result, 32'd113);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
